// File: rtl/serial_frame_rx.sv
// Oversampled serial frame receiver: start detect, mid-bit sampling, optional even
// parity, stop check, and a valid/ready output holding one received word.
module serial_frame_rx #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned OVERSAMPLE = 4,
  parameter int unsigned PARITY_EN  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  input  logic              ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BW = $clog2(DATA_W + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_END   = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_next;
  logic              par_bit;
  logic              perr_calc;

  // Serial data arrives LSB first, so each new bit enters at the top and moves down.
  always_comb begin
    shift_next = '0;
    for (int unsigned i = 0; i + 1 < DATA_W; i++) begin
      shift_next[i] = shift[i+1];
    end
    shift_next[DATA_W-1] = d;
  end

  always_comb begin
    perr_calc = 1'b0;
    if (PARITY_EN != 0) begin
      perr_calc = (^shift) ^ par_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (valid && ready) begin
        valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!d) begin
            state <= START;
            cnt   <= '0;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= d ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DATA: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            shift <= shift_next;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        PARITY: begin
          if (cnt == BIT_END) begin
            cnt     <= '0;
            par_bit <= d;
            state   <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        STOP: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            state <= IDLE;
            if (!d) begin
              frame_err <= 1'b1;
            end else if (!valid || ready) begin
              // A same-cycle accept frees the slot, so the new word loads instead of overrunning.
              data_out   <= shift;
              parity_err <= perr_calc;
              valid      <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
